// File: rtl/dialogue_text_engine.sv
// Dialogue text box engine: buffers a glyph string, reveals it typewriter-style and turns the
// current pixel into font-stage glyph requests. Optional "more" cursor: define CURSOR_BLINK_EN.
module dialogue_text_engine #(
  parameter int COLS        = 16,
  parameter int ROWS        = 2,
  parameter int BOX_X       = 32,
  parameter int BOX_Y       = 400,
  parameter int FONT_COLS   = 17,
  parameter int FONT_ROWS   = 11,
  parameter int REVEAL_DIV  = 2,
  parameter int CURSOR_CODE = 186
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        frame_tick_in,
  input  logic        char_valid_in,
  input  logic [7:0]  char_code_in,
  output logic        char_ready_out,
  input  logic        start_in,
  input  logic        advance_in,
  output logic        busy_out,
  output logic        done_out,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic [9:0]  sprite_sel_x_out,
  output logic [8:0]  sprite_sel_y_out,
  output logic        glyph_visible_out
);

  localparam int CAP = COLS * ROWS;
  localparam int CW  = $clog2(CAP + 1);
  localparam int IW  = (CAP > 1) ? $clog2(CAP) : 1;
  localparam int DW  = $clog2(REVEAL_DIV + 1);

  typedef enum logic [1:0] {IDLE, LOAD, REVEAL, WAIT_ADV} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  fill, fill_n, reveal, reveal_n;
  logic [DW-1:0]  frame_div, frame_div_n;
  logic           wr_en;
  logic [7:0]     buf_mem [CAP];

  assign char_ready_out = (state == LOAD) && (fill < CW'(CAP));
  assign busy_out       = (state == REVEAL);
  assign done_out       = (state == WAIT_ADV);

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      fill      <= '0;
      reveal    <= '0;
      frame_div <= '0;
    end else begin
      state     <= state_n;
      fill      <= fill_n;
      reveal    <= reveal_n;
      frame_div <= frame_div_n;
    end
  end

  // Buffer contents need no reset: fill/reveal gate everything read from it.
  always_ff @(posedge pixel_clk_in) begin
    if (wr_en) buf_mem[fill[IW-1:0]] <= char_code_in;
  end

  always_comb begin
    state_n     = state;
    fill_n      = fill;
    reveal_n    = reveal;
    frame_div_n = frame_div;
    wr_en       = 1'b0;
    case (state)
      IDLE: state_n = LOAD;
      LOAD: begin
        wr_en = char_valid_in && char_ready_out;
        if (wr_en) fill_n = fill + CW'(1);
        if (start_in) begin
          reveal_n    = '0;
          frame_div_n = '0;
          state_n     = (fill_n == '0) ? WAIT_ADV : REVEAL;
        end
      end
      REVEAL: begin
        if (advance_in) begin
          reveal_n = fill;
          state_n  = WAIT_ADV;
        end else if (reveal == fill) begin
          state_n = WAIT_ADV;
        end else if (frame_tick_in) begin
          if (frame_div == DW'(REVEAL_DIV - 1)) begin
            reveal_n    = reveal + CW'(1);
            frame_div_n = '0;
          end else begin
            frame_div_n = frame_div + DW'(1);
          end
        end
      end
      WAIT_ADV: begin
        if (advance_in) begin
          fill_n   = '0;
          reveal_n = '0;
          state_n  = LOAD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef CURSOR_BLINK_EN
  logic [5:0] blink_cnt;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) blink_cnt <= '0;
    else if (state_n == WAIT_ADV && state != WAIT_ADV) blink_cnt <= '0;
    else if (frame_tick_in) blink_cnt <= blink_cnt + 6'd1;
  end
`endif

  logic [10:0]   h_off;
  logic [9:0]    v_off;
  logic          in_box, revealed, drawable;
  logic [CW-1:0] pix_idx;
  logic [7:0]    cell_code, glyph_q, glyph_r;

  // Pixel-to-cell mapping; everything below feeds the single output register stage.
  always_comb begin
    h_off     = hcount_in - 11'(BOX_X);
    v_off     = vcount_in - 10'(BOX_Y);
    in_box    = (hcount_in >= 11'(BOX_X)) && (hcount_in < 11'(BOX_X + 8 * COLS)) &&
                (vcount_in >= 10'(BOX_Y)) && (vcount_in < 10'(BOX_Y + 8 * ROWS));
    pix_idx   = CW'(int'(v_off >> 3) * COLS + int'(h_off >> 3));
    cell_code = buf_mem[pix_idx[IW-1:0]];
    revealed  = pix_idx < reveal;
`ifdef CURSOR_BLINK_EN
    if (state == WAIT_ADV && pix_idx == CW'(CAP - 1)) begin
      cell_code = 8'(CURSOR_CODE);
      revealed  = blink_cnt[5];
    end
`endif
    drawable  = in_box && revealed && (cell_code != 8'd0) &&
                (int'(cell_code) < FONT_COLS * FONT_ROWS);
    glyph_q   = cell_code / 8'(FONT_COLS);
    glyph_r   = cell_code % 8'(FONT_COLS);
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      x_out             <= 11'h7FF;
      y_out             <= 10'h3FF;
      sprite_sel_x_out  <= '0;
      sprite_sel_y_out  <= '0;
      glyph_visible_out <= 1'b0;
    end else if (drawable) begin
      x_out             <= 11'(BOX_X) + (h_off & ~11'h7);
      y_out             <= 10'(BOX_Y) + (v_off & ~10'h7);
      sprite_sel_x_out  <= 10'({glyph_r, 3'b000});
      sprite_sel_y_out  <= 9'({glyph_q, 3'b000});
      glyph_visible_out <= 1'b1;
    end else begin
      x_out             <= 11'h7FF;
      y_out             <= 10'h3FF;
      sprite_sel_x_out  <= '0;
      sprite_sel_y_out  <= '0;
      glyph_visible_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dialogue_text_engine.sv
// Directed bench for dialogue_text_engine: a reference model predicts every pixel request and
// a scoreboard queue matches predictions against the registered DUT outputs.
module tb_dialogue_text_engine;

  localparam int COLS = 16, ROWS = 2, BOX_X = 32, BOX_Y = 400, FONT_COLS = 17, FONT_ROWS = 11;
  localparam int CAP = COLS * ROWS;

  logic        pixel_clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic        frame_tick_in = 1'b0, char_valid_in = 1'b0, start_in = 1'b0, advance_in = 1'b0;
  logic [7:0]  char_code_in = '0;
  logic        char_ready_out, busy_out, done_out, glyph_visible_out;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic [9:0]  sprite_sel_x_out;
  logic [8:0]  sprite_sel_y_out;

  dialogue_text_engine dut (
    .pixel_clk_in(pixel_clk_in), .rst_n_in(rst_n_in), .hcount_in(hcount_in),
    .vcount_in(vcount_in), .frame_tick_in(frame_tick_in), .char_valid_in(char_valid_in),
    .char_code_in(char_code_in), .char_ready_out(char_ready_out), .start_in(start_in),
    .advance_in(advance_in), .busy_out(busy_out), .done_out(done_out), .x_out(x_out),
    .y_out(y_out), .sprite_sel_x_out(sprite_sel_x_out), .sprite_sel_y_out(sprite_sel_y_out),
    .glyph_visible_out(glyph_visible_out)
  );

  always #5 pixel_clk_in = ~pixel_clk_in;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic [9:0]  sx;
    logic [8:0]  sy;
    logic        vis;
  } pix_t;

  pix_t       exp_q[$];
  logic [7:0] m_buf [CAP];
  int         m_fill = 0;
  int         m_reveal = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  int         n_fail = 0;

  task automatic cyc();
    @(negedge pixel_clk_in);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model of one pixel request, derived from the box geometry and model buffer.
  function automatic pix_t model_pixel(input int h, input int v, input int rev);
    pix_t p;
    int col, row, idx, code;
    p = '{x: 11'h7FF, y: 10'h3FF, sx: '0, sy: '0, vis: 1'b0};
    if (h >= BOX_X && h < BOX_X + 8 * COLS && v >= BOY(0) && v < BOX_Y + 8 * ROWS) begin
      col  = (h - BOX_X) / 8;
      row  = (v - BOX_Y) / 8;
      idx  = row * COLS + col;
      code = int'(m_buf[idx]);
      if (idx < rev && code != 0 && code < FONT_COLS * FONT_ROWS) begin
        p.x   = 11'(BOX_X + col * 8);
        p.y   = 10'(BOX_Y + row * 8);
        p.sx  = 10'((code % FONT_COLS) * 8);
        p.sy  = 9'((code / FONT_COLS) * 8);
        p.vis = 1'b1;
      end
    end
    return p;
  endfunction

  function automatic int BOY(input int dummy);
    return BOX_Y + dummy;
  endfunction

  // Drive one pixel, predict it, and compare once the registered result appears.
  task automatic applyStimulus(input string tag, input int h, input int v);
    pix_t e;
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    exp_q.push_back(model_pixel(h, v, m_reveal));
    cyc();
    if (exp_q.size() == 0) begin
      checkOutput({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      checkOutput({tag, "_x"}, 32'(x_out), 32'(e.x));
      checkOutput({tag, "_y"}, 32'(y_out), 32'(e.y));
      checkOutput({tag, "_sx"}, 32'(sprite_sel_x_out), 32'(e.sx));
      checkOutput({tag, "_sy"}, 32'(sprite_sel_y_out), 32'(e.sy));
      checkOutput({tag, "_vis"}, 32'(glyph_visible_out), 32'(e.vis));
    end
  endtask

  task automatic loadChar(input int code);
    char_valid_in = 1'b1;
    char_code_in  = 8'(code);
    if (m_fill < CAP) begin
      m_buf[m_fill] = 8'(code);
      m_fill++;
    end
    cyc();
    char_valid_in = 1'b0;
  endtask

  task automatic pulse(input int which);
    if (which == 0) start_in = 1'b1;
    else if (which == 1) advance_in = 1'b1;
    else frame_tick_in = 1'b1;
    cyc();
    start_in = 1'b0;
    advance_in = 1'b0;
    frame_tick_in = 1'b0;
  endtask

  task automatic checkStatus(input string tag, input logic rdy, input logic bsy, input logic dn);
    checkOutput({tag, "_ready"}, 32'(char_ready_out), 32'(rdy));
    checkOutput({tag, "_busy"}, 32'(busy_out), 32'(bsy));
    checkOutput({tag, "_done"}, 32'(done_out), 32'(dn));
  endtask

  initial begin
    for (int i = 0; i < CAP; i++) m_buf[i] = '0;
    repeat (3) cyc();
    // reset values
    checkStatus("rst", 1'b0, 1'b0, 1'b0);
    checkOutput("rst_x", 32'(x_out), 32'h7FF);
    checkOutput("rst_y", 32'(y_out), 32'h3FF);
    checkOutput("rst_vis", 32'(glyph_visible_out), 32'd0);
    rst_n_in = 1'b1;
    cyc();
    cyc();
    checkStatus("load0", 1'b1, 1'b0, 1'b0);

    // "HI" typewriter reveal
    loadChar(8);
    loadChar(9);
    pulse(0);
    checkStatus("hi_rev", 1'b0, 1'b1, 1'b0);
    applyStimulus("hi_idx0_hidden", BOX_X, BOX_Y);
    pulse(2);
    applyStimulus("hi_idx0_tick1", BOX_X + 3, BOX_Y + 3);
    pulse(2);
    m_reveal = 1;
    applyStimulus("hi_idx0_tick2", BOX_X, BOX_Y);
    applyStimulus("hi_idx1_tick2", BOX_X + 8, BOX_Y);
    pulse(2);
    pulse(2);
    m_reveal = 2;
    checkStatus("hi_tick4", 1'b0, 1'b1, 1'b0);
    cyc();
    checkStatus("hi_done", 1'b0, 1'b0, 1'b1);
    applyStimulus("hi_idx1", BOX_X + 8, BOX_Y + 7);

    // next page: buf[1]=20 pixel mapping and box boundaries
    pulse(1);
    m_fill = 0;
    m_reveal = 0;
    checkStatus("pg2_load", 1'b1, 1'b0, 1'b0);
    applyStimulus("pg2_blank", BOX_X, BOX_Y);
    loadChar(5);
    loadChar(20);
    pulse(0);
    pulse(1);
    m_reveal = m_fill;
    checkStatus("pg2_skip", 1'b0, 1'b0, 1'b1);
    applyStimulus("pix_20", BOX_X + 13, BOX_Y + 2);
    applyStimulus("left_edge", BOX_X - 1, BOX_Y);
    applyStimulus("right_edge", BOX_X + 8 * COLS, BOX_Y);
    applyStimulus("bottom_edge", BOX_X, BOX_Y + 8 * ROWS);
    applyStimulus("top_edge", BOX_X, BOX_Y - 1);

    // skip mid-reveal with fill=10, reveal=3; includes undrawable codes 0 and 200
    pulse(1);
    m_fill = 0;
    m_reveal = 0;
    loadChar(65);
    loadChar(0);
    loadChar(200);
    for (int i = 3; i < 10; i++) loadChar(i + 40);
    pulse(0);
    for (int i = 0; i < 6; i++) pulse(2);
    m_reveal = 3;
    checkStatus("skip_mid", 1'b0, 1'b1, 1'b0);
    applyStimulus("skip_idx0", BOX_X, BOX_Y);
    applyStimulus("skip_idx3_hidden", BOX_X + 24, BOX_Y);
    pulse(1);
    m_reveal = 10;
    checkStatus("skip_done", 1'b0, 1'b0, 1'b1);
    applyStimulus("skip_idx9", BOX_X + 72 + 4, BOX_Y + 5);
    applyStimulus("code0", BOX_X + 8, BOX_Y);
    applyStimulus("code200", BOX_X + 16, BOX_Y);
    pulse(1);
    m_fill = 0;
    m_reveal = 0;
    checkStatus("adv_load", 1'b1, 1'b0, 1'b0);
    applyStimulus("adv_blank", BOX_X, BOX_Y);

    // full buffer: 33 offered, 32 accepted
    for (int i = 0; i < CAP + 1; i++) begin
      checkOutput($sformatf("full_ready%0d", i), 32'(char_ready_out), 32'(m_fill < CAP));
      loadChar(i + 1);
    end
    checkOutput("full_ready_end", 32'(char_ready_out), 32'd0);
    pulse(0);
    pulse(1);
    m_reveal = m_fill;
    applyStimulus("full_idx31", BOX_X + 8 * 15 + 7, BOX_Y + 15);

    // asynchronous reset mid-reveal
    pulse(1);
    m_fill = 0;
    m_reveal = 0;
    loadChar(8);
    loadChar(9);
    loadChar(10);
    pulse(0);
    pulse(2);
    pulse(2);
    hcount_in = 11'(BOX_X);
    vcount_in = 10'(BOX_Y);
    cyc();
    checkOutput("pre_rst_vis", 32'(glyph_visible_out), 32'd1);
    rst_n_in = 1'b0;
    #1;
    checkStatus("async_rst", 1'b0, 1'b0, 1'b0);
    checkOutput("async_rst_x", 32'(x_out), 32'h7FF);
    checkOutput("async_rst_y", 32'(y_out), 32'h3FF);
    checkOutput("async_rst_vis", 32'(glyph_visible_out), 32'd0);
    cyc();
    rst_n_in = 1'b1;
    m_fill = 0;
    m_reveal = 0;
    applyStimulus("post_rst_blank", BOX_X, BOX_Y);
    cyc();
    checkStatus("post_rst_load", 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
